fp_add_pipe: RTL and testbench

FP_ADD_PIPE -- requirements
Module: fp_add_pipe

---
 rtl/fp_pkg.sv | 30 +++
 rtl/fp_lzc.sv | 17 +
 rtl/fp_add_pipe.sv | 234 +++++++++++++++++++++++
 tb/tb_fp_add_pipe.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point adder: default formats,
// flag positions and the unpacked operand record used during classification.
package fp_pkg;

    localparam int FP_EXP_W    = 8;
    localparam int FP_MAN_W    = 23;
    localparam int FP_EXP_MAXW = 16;
    localparam int FP_SIG_MAXW = 64;

    localparam logic [31:0] FP_QNAN_32 = 32'h7FC0_0000;

    localparam int FLAG_INVALID  = 2;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_INEXACT  = 0;

    // Fields are sized for the widest supported format; narrower formats zero-extend.
    typedef struct packed {
        logic                   sign;
        logic [FP_EXP_MAXW-1:0] exp;
        logic [FP_SIG_MAXW-1:0] sig;
        logic                   is_zero;
        logic                   is_inf;
        logic                   is_nan;
    } fp_op_t;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
    parameter int WIDTH = 27,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] din,
    output logic [CNT_W-1:0] cnt
);

    always_comb begin
        cnt = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (din[i]) cnt = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage IEEE-754-style adder/subtractor with round-to-nearest-even,
// subnormal flush and a single stall signal shared by all stages.
module fp_add_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   op_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [2:0]             flags
);

    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int SIG_W  = MAN_W + 1;
    localparam int SH_MAX = MAN_W + 3;
    localparam int ALN_W  = MAN_W + 4;
    localparam int ADD_W  = MAN_W + 5;
    localparam int LZ_W   = $clog2(ALN_W + 1);

    localparam logic [EXP_W:0] EXP_INF = (EXP_W+1)'(2 * fp_bias(EXP_W) + 1);
    localparam logic [W-1:0]   QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-1:0]   INF_MAG = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

    function automatic fp_op_t unpack(input logic [W-1:0] x, input logic flip);
        fp_op_t u;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        e         = x[W-2:MAN_W];
        f         = x[MAN_W-1:0];
        u.sign    = x[W-1] ^ flip;
        u.is_zero = ~|e;
        u.is_inf  = (&e) & ~|f;
        u.is_nan  = (&e) & (|f);
        u.exp     = FP_EXP_MAXW'(e);
        u.sig     = u.is_zero ? '0 : FP_SIG_MAXW'({1'b1, f});
        return u;
    endfunction

    // Saturating right shift; everything pushed past the round bit folds into sticky.
    function automatic logic [ALN_W-1:0] align(input logic [SIG_W-1:0] sig,
                                               input logic [EXP_W-1:0] diff);
        logic [EXP_W-1:0]    sh;
        logic [2*SH_MAX-1:0] wide;
        sh   = (diff > EXP_W'(SH_MAX)) ? EXP_W'(SH_MAX) : diff;
        wide = {sig, 2'b00, {SH_MAX{1'b0}}} >> sh;
        return {wide[2*SH_MAX-1 -: SH_MAX], |wide[SH_MAX-1:0]};
    endfunction

    function automatic logic [MAN_W+1:0] round_rne(input logic [ALN_W-1:0] man);
        logic inc;
        inc = man[2] & (man[1] | man[0] | man[3]);
        return {1'b0, man[ALN_W-1:3]} + (MAN_W+2)'(inc);
    endfunction

    logic advance;
    logic vld_p0, vld_p1, vld_p2;

    assign advance   = ~vld_p2 | out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_p2;

    // ---- S1: unpack, classify, swap, align ----
    fp_op_t            ua, ub;
    logic              mag_ge;
    logic [SIG_W-1:0]  big_sig, sml_sig;
    logic [EXP_W-1:0]  big_exp, sml_exp;
    logic [ALN_W-1:0]  sml_aln;
    logic              s1_spec;
    logic [W-1:0]      s1_spec_res;
    logic [2:0]        s1_spec_flg;

    always_comb begin
        ua      = unpack(a, 1'b0);
        ub      = unpack(b, op_sub);
        mag_ge  = {ua.exp, ua.sig} >= {ub.exp, ub.sig};
        big_sig = mag_ge ? ua.sig[SIG_W-1:0] : ub.sig[SIG_W-1:0];
        sml_sig = mag_ge ? ub.sig[SIG_W-1:0] : ua.sig[SIG_W-1:0];
        big_exp = mag_ge ? ua.exp[EXP_W-1:0] : ub.exp[EXP_W-1:0];
        sml_exp = mag_ge ? ub.exp[EXP_W-1:0] : ua.exp[EXP_W-1:0];
        sml_aln = align(sml_sig, big_exp - sml_exp);

        s1_spec     = ua.is_nan | ub.is_nan | ua.is_inf | ub.is_inf | (ua.is_zero & ub.is_zero);
        s1_spec_res = '0;
        s1_spec_flg = '0;
        if (ua.is_nan || ub.is_nan) begin
            s1_spec_res = QNAN;
        end else if (ua.is_inf && ub.is_inf && (ua.sign != ub.sign)) begin
            s1_spec_res               = QNAN;
            s1_spec_flg[FLAG_INVALID] = 1'b1;
        end else if (ua.is_inf) begin
            s1_spec_res = INF_MAG | {ua.sign, {(W-1){1'b0}}};
        end else if (ub.is_inf) begin
            s1_spec_res = INF_MAG | {ub.sign, {(W-1){1'b0}}};
        end else begin
            s1_spec_res = {ua.sign & ub.sign, {(W-1){1'b0}}};
        end
    end

    logic             spec_p0, sign_p0, sub_p0;
    logic [W-1:0]     spec_res_p0;
    logic [2:0]       spec_flg_p0;
    logic [EXP_W-1:0] exp_p0;
    logic [ALN_W-1:0] big_p0, sml_p0;

    always_ff @(posedge clk) begin
        if (advance) begin
            spec_p0     <= s1_spec;
            spec_res_p0 <= s1_spec_res;
            spec_flg_p0 <= s1_spec_flg;
            sign_p0     <= mag_ge ? ua.sign : ub.sign;
            sub_p0      <= ua.sign ^ ub.sign;
            exp_p0      <= big_exp;
            big_p0      <= {big_sig, 3'b000};
            sml_p0      <= sml_aln;
        end
    end

    // ---- S2: add/subtract, normalise ----
    logic [ADD_W-1:0] sum;
    logic [LZ_W-1:0]  lz;
    logic [EXP_W:0]   exp_ext, nrm_exp;
    logic [ALN_W-1:0] nrm_man;
    logic             nrm_zero, nrm_sign;

    assign sum     = sub_p0 ? ({1'b0, big_p0} - {1'b0, sml_p0})
                            : ({1'b0, big_p0} + {1'b0, sml_p0});
    assign exp_ext = {1'b0, exp_p0};

    fp_lzc #(.WIDTH(ALN_W), .CNT_W(LZ_W)) u_lzc (
        .din (sum[ALN_W-1:0]),
        .cnt (lz)
    );

    always_comb begin
        nrm_man  = '0;
        nrm_exp  = '0;
        nrm_zero = 1'b0;
        nrm_sign = sign_p0;
        if (sum[ADD_W-1]) begin
            nrm_man = {sum[ADD_W-1:2], sum[1] | sum[0]};
            nrm_exp = exp_ext + 1'b1;
        end else if (sum[ALN_W-1:0] == '0) begin
            nrm_zero = 1'b1;
            nrm_sign = 1'b0;
        end else if (exp_ext <= (EXP_W+1)'(lz)) begin
            nrm_zero = 1'b1;
        end else begin
            nrm_man = sum[ALN_W-1:0] << lz;
            nrm_exp = exp_ext - (EXP_W+1)'(lz);
        end
    end

    logic             spec_p1, sign_p1, zero_p1;
    logic [W-1:0]     spec_res_p1;
    logic [2:0]       spec_flg_p1;
    logic [EXP_W:0]   exp_p1;
    logic [ALN_W-1:0] man_p1;

    always_ff @(posedge clk) begin
        if (advance) begin
            spec_p1     <= spec_p0;
            spec_res_p1 <= spec_res_p0;
            spec_flg_p1 <= spec_flg_p0;
            sign_p1     <= nrm_sign;
            zero_p1     <= nrm_zero;
            exp_p1      <= nrm_exp;
            man_p1      <= nrm_man;
        end
    end

    // ---- S3: round, detect overflow, pack ----
    logic [MAN_W+1:0] rnd;
    logic [EXP_W:0]   fin_exp;
    logic [MAN_W-1:0] fin_frac;
    logic             inexact;
    logic [W-1:0]     res_d;
    logic [2:0]       flg_d;

    always_comb begin
        rnd     = round_rne(man_p1);
        inexact = |man_p1[2:0];
        if (rnd[MAN_W+1]) begin
            fin_exp  = exp_p1 + 1'b1;
            fin_frac = rnd[MAN_W:1];
        end else begin
            fin_exp  = exp_p1;
            fin_frac = rnd[MAN_W-1:0];
        end

        res_d = '0;
        flg_d = '0;
        if (spec_p1) begin
            res_d = spec_res_p1;
            flg_d = spec_flg_p1;
        end else if (zero_p1) begin
            res_d = {sign_p1, {(W-1){1'b0}}};
        end else if (fin_exp >= EXP_INF) begin
            res_d                = INF_MAG | {sign_p1, {(W-1){1'b0}}};
            flg_d[FLAG_OVERFLOW] = 1'b1;
            flg_d[FLAG_INEXACT]  = 1'b1;
        end else begin
            res_d               = {sign_p1, fin_exp[EXP_W-1:0], fin_frac};
            flg_d[FLAG_INEXACT] = inexact;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            result <= '0;
            flags  <= '0;
        end else if (advance) begin
            vld_p0 <= in_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                result <= res_d;
                flags  <= flg_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe: vector table, back-pressure and mid-flight reset.
module tb_fp_add_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        op_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [2:0]  flags;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic [2:0]  flg;
        string       name;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v);
        bit found;
        int lat;
        found = 0;
        lat   = 0;
        @(negedge clk);
        a        = v.a;
        b        = v.b;
        op_sub   = v.sub;
        in_valid = 1'b1;
        #1;
        check({v.name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                found = 1;
                lat   = i + 1;
            end
        end
        if (!found) begin
            check({v.name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({v.name, "_latency"}, 32'(lat), 32'd3);
            check({v.name, "_result"}, result, v.res);
            check({v.name, "_flags"}, 32'(flags), 32'(v.flg));
        end
    endtask

    initial begin
        int   bp_idx[6];
        int   tx, rx, stalls;
        bit   stray;

        vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, "add_1_2"};
        vecs[1]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, "tie_even"};
        vecs[2]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001, "tie_up"};
        vecs[3]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, "cancel"};
        vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011, "overflow"};
        vecs[5]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100, "inf_m_inf"};
        vecs[6]  = '{32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000, "nan_in"};
        vecs[7]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, "sub_3_1"};
        vecs[8]  = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000, "sub_1_2"};
        vecs[9]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000, "inf_p_1"};
        vecs[10] = '{32'hFF800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000, "ninf_s_inf"};
        vecs[11] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000, "nz_p_nz"};
        vecs[12] = '{32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 3'b000, "nz_s_nz"};
        vecs[13] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000, "subnormal"};
        vecs[14] = '{32'h00000000, 32'hBF800000, 1'b0, 32'hBF800000, 3'b000, "z_p_neg1"};
        vecs[15] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b000, "flush"};
        vecs[16] = '{32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 3'b000, "carry_1p5"};
        vecs[17] = '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 3'b001, "round_carry"};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_result", result, 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) run_vec(vecs[i]);

        // Back-pressure: back-to-back inputs, consumer stalls 5 cycles once output appears
        bp_idx = '{0, 7, 8, 16, 17, 4};
        tx = 0;
        rx = 0;
        stalls = 0;
        for (int cyc = 0; cyc < 60 && rx < 6; cyc++) begin
            @(negedge clk);
            out_ready = !(out_valid && stalls < 5);
            if (tx < 6) begin
                a        = vecs[bp_idx[tx]].a;
                b        = vecs[bp_idx[tx]].b;
                op_sub   = vecs[bp_idx[tx]].sub;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                check("bp_hold_result", result, vecs[bp_idx[rx]].res);
                check("bp_in_ready_full", 32'(in_ready), 32'd0);
            end else if (out_valid && out_ready) begin
                check("bp_result", result, vecs[bp_idx[rx]].res);
                check("bp_flags", 32'(flags), 32'(vecs[bp_idx[rx]].flg));
                rx++;
            end
            if (in_valid && in_ready) tx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_received", 32'(rx), 32'd6);
        check("bp_stall_cycles", 32'(stalls), 32'd5);

        // Reset with operations in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a        = vecs[i].a;
            b        = vecs[i].b;
            op_sub   = vecs[i].sub;
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_flags", 32'(flags), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stray = 1;
        end
        check("post_rst_no_stale", 32'(stray), 32'd0);
        run_vec(vecs[16]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
